// File: rtl/audio_framer.sv
// rtl/audio_framer.sv - frames one PCM channel into overlapping analysis frames
//
// Purpose: accepts 24-bit samples from the selected I2S channel, optionally
// pre-emphasises them, stores them in a circular RAM and streams a frame of
// FRAME_LEN samples every HOP accepted samples.
// Optional feature macro: FRAMER_PREEMPH_EN (pre-emphasis filter in input path).
//
// Ports:
//   cmn_clk, cmn_rst          clock, asynchronous active-high reset
//   tvalid_l_data, l_data     left sample strobe and data (signed 24-bit)
//   tvalid_r_data, r_data     right sample strobe and data (signed 24-bit)
//   m_tvalid, m_tready        frame stream handshake
//   m_tdata, m_tlast          frame sample, last-sample-of-frame marker
//   m_frame_idx               frame counter, constant for a whole frame
//   overrun                   sticky error flag
module audio_framer #(
  parameter logic        CHOOSE_CHANNEL = 1'b0,
  parameter int          FRAME_LEN      = 256,
  parameter int          HOP            = 128,
  parameter int          BUF_AW         = 9,
  parameter logic [15:0] PRE_EMPH_COEF  = 16'd31785
) (
  input  logic        cmn_clk,
  input  logic        cmn_rst,
  input  logic        tvalid_l_data,
  input  logic [23:0] l_data,
  input  logic        tvalid_r_data,
  input  logic [23:0] r_data,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [23:0] m_tdata,
  output logic        m_tlast,
  output logic [15:0] m_frame_idx,
  output logic        overrun
);

  localparam int                CW     = BUF_AW + 1;
  localparam logic [CW-1:0]     FL_C   = CW'(FRAME_LEN);
  localparam logic [CW-1:0]     FL_M1  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]     HOP_M1 = CW'(HOP - 1);
  localparam logic [CW-1:0]     C_ONE  = CW'(1);
  localparam logic [BUF_AW-1:0] FL_A   = BUF_AW'(FRAME_LEN);
  localparam logic [BUF_AW-1:0] A_ONE  = BUF_AW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [23:0]       r_mem [0:(1<<BUF_AW)-1];

  logic              w_acc;
  logic [23:0]       w_raw;
  logic [23:0]       w_store;
  logic              w_trig;
  logic [BUF_AW-1:0] w_wr_nxt;
  logic [BUF_AW-1:0] w_start;

  logic [BUF_AW-1:0] r_wr_ptr;
  logic [CW-1:0]     r_fill;
  logic [CW-1:0]     r_hop;
  logic              r_trig;
  logic [BUF_AW-1:0] r_trig_addr;

  logic [1:0]        r_state;
  logic [BUF_AW-1:0] r_rd_addr;
  logic [BUF_AW-1:0] r_frame_start;
  logic [CW-1:0]     r_cnt;
  logic              r_pending;
  logic [BUF_AW-1:0] r_pend_addr;
  logic              r_tvalid;
  logic [23:0]       r_tdata;
  logic              r_tlast;
  logic [15:0]       r_frame_idx;
  logic              r_overrun;

  logic              w_done;
  logic              w_launch;
  logic [BUF_AW-1:0] w_launch_addr;
  logic              w_wr_clash;

  assign w_acc = CHOOSE_CHANNEL ? tvalid_r_data : tvalid_l_data;
  assign w_raw = CHOOSE_CHANNEL ? r_data : l_data;

`ifdef FRAMER_PREEMPH_EN
  logic [23:0]        r_x_prev;
  logic signed [40:0] w_prod;
  logic signed [40:0] w_y;

  assign w_prod = $signed({{17{r_x_prev[23]}}, r_x_prev}) * $signed({25'd0, PRE_EMPH_COEF});
  assign w_y    = $signed({{17{w_raw[23]}}, w_raw}) - (w_prod >>> 15);

  always_comb begin
    w_store = w_y[23:0];
    if (w_y > 41'sd8388607)
      w_store = 24'h7FFFFF;
    else if (w_y < -41'sd8388608)
      w_store = 24'h800000;
  end

  // x_prev tracks the raw input, not the filtered value
  always_ff @(posedge cmn_clk or posedge cmn_rst) begin
    if (cmn_rst)
      r_x_prev <= 24'd0;
    else if (w_acc)
      r_x_prev <= w_raw;
  end
`else
  logic w_unused_coef;
  assign w_unused_coef = ^PRE_EMPH_COEF;
  assign w_store       = w_raw;
`endif

  assign w_wr_nxt = r_wr_ptr + A_ONE;
  assign w_start  = w_wr_nxt - FL_A;
  assign w_trig   = w_acc && ((r_fill == FL_M1) || ((r_fill == FL_C) && (r_hop == HOP_M1)));

  always_ff @(posedge cmn_clk) begin
    if (w_acc)
      r_mem[r_wr_ptr] <= w_store;
  end

  // Trigger is registered so the reader sees the sample already in RAM.
  always_ff @(posedge cmn_clk or posedge cmn_rst) begin
    if (cmn_rst) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_hop       <= '0;
      r_trig      <= 1'b0;
      r_trig_addr <= '0;
    end else begin
      r_trig <= w_trig;
      if (w_trig)
        r_trig_addr <= w_start;
      if (w_acc) begin
        r_wr_ptr <= w_wr_nxt;
        if (r_fill != FL_C)
          r_fill <= r_fill + C_ONE;
        if (w_trig)
          r_hop <= '0;
        else if (r_fill == FL_C)
          r_hop <= r_hop + C_ONE;
      end
    end
  end

  // A frame can start from IDLE or directly on the final transfer of the
  // previous frame; a pending start is older than a fresh trigger.
  assign w_done        = (r_state == S_STREAM) && r_tvalid && m_tready && r_tlast;
  assign w_launch      = ((r_state == S_IDLE) || w_done) && (r_pending || r_trig);
  assign w_launch_addr = r_pending ? r_pend_addr : r_trig_addr;
  assign w_wr_clash    = (r_state != S_IDLE) && w_acc && (r_wr_ptr == r_frame_start);

  always_ff @(posedge cmn_clk or posedge cmn_rst) begin
    if (cmn_rst) begin
      r_state       <= S_IDLE;
      r_rd_addr     <= '0;
      r_frame_start <= '0;
      r_cnt         <= '0;
      r_pending     <= 1'b0;
      r_pend_addr   <= '0;
      r_tvalid      <= 1'b0;
      r_tdata       <= 24'd0;
      r_tlast       <= 1'b0;
      r_frame_idx   <= 16'd0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_wr_clash)
        r_overrun <= 1'b1;

      if (w_launch) begin
        // a trigger arriving while pending launches takes the freed slot
        r_pending   <= r_pending && r_trig;
        r_pend_addr <= r_trig_addr;
      end else if (r_trig) begin
        if (r_pending)
          r_overrun <= 1'b1;
        else begin
          r_pending   <= 1'b1;
          r_pend_addr <= r_trig_addr;
        end
      end

      case (r_state)
        S_IDLE: ;
        S_FETCH: begin
          r_tdata   <= r_mem[r_rd_addr];
          r_rd_addr <= r_rd_addr + A_ONE;
          r_tvalid  <= 1'b1;
          r_tlast   <= 1'b0;
          r_cnt     <= C_ONE;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          if (r_tvalid && m_tready) begin
            if (r_tlast) begin
              r_tvalid    <= 1'b0;
              r_tlast     <= 1'b0;
              r_frame_idx <= r_frame_idx + 16'd1;
              r_state     <= S_IDLE;
            end else begin
              // prefetch the next sample into the output register
              r_tdata   <= r_mem[r_rd_addr];
              r_rd_addr <= r_rd_addr + A_ONE;
              r_cnt     <= r_cnt + C_ONE;
              r_tlast   <= (r_cnt == FL_M1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_launch) begin
        r_rd_addr     <= w_launch_addr;
        r_frame_start <= w_launch_addr;
        r_state       <= S_FETCH;
      end
    end
  end

  assign m_tvalid    = r_tvalid;
  assign m_tdata     = r_tdata;
  assign m_tlast     = r_tlast;
  assign m_frame_idx = r_frame_idx;
  assign overrun     = r_overrun;

endmodule

// File: doc/audio_framer.md
# audio_framer

Sits between the ADC capture controller and the log-filterbank feature stage. It takes one selected channel of 24-bit PCM samples, optionally applies a fixed-point pre-emphasis filter, and writes them into a circular sample RAM. It then emits overlapping analysis frames of FRAME_LEN samples every HOP samples on a ready/valid stream. The feature stage consumes the frames without ever seeing the I2S sample cadence.

## Interface
Parameters:
- CHOOSE_CHANNEL, 1'b0: input channel to frame; 0 = left, 1 = right.
- FRAME_LEN, 256: samples per frame, in 2..2^BUF_AW-HOP.
- HOP, 128: new samples between frame starts, in 1..FRAME_LEN.
- BUF_AW, 9: sample RAM address width; depth is 2^BUF_AW.
- PRE_EMPH_COEF, 16'd31785: pre-emphasis coefficient, unsigned Q1.15 (0.97).

Ports:
- cmn_clk, in, 1: common clock (100 MHz).
- cmn_rst, in, 1: asynchronous, active-high reset.
- tvalid_l_data, in, 1: one-cycle strobe; l_data is valid in that cycle.
- l_data, in, 24: left sample, signed two's complement.
- tvalid_r_data, in, 1: one-cycle strobe for r_data.
- r_data, in, 24: right sample, signed.
- m_tvalid, out, 1: frame sample valid.
- m_tready, in, 1: downstream accepts the sample.
- m_tdata, out, 24: frame sample, signed.
- m_tlast, out, 1: high on the last sample of a frame.
- m_frame_idx, out, 16: frame counter; starts at 0, increments per frame, wraps at 65535.
- overrun, out, 1: sticky error flag; cleared only by reset.

## Operation
Input path:
- The selected strobe writes a sample at wr_ptr, then wr_ptr increments mod 2^BUF_AW.
- The strobe of the unselected channel is ignored.
- fill_cnt counts accepted samples and saturates at FRAME_LEN.
- hop_cnt counts samples accepted since the last trigger.
- First trigger: the accepted sample that makes fill_cnt reach FRAME_LEN.
- Later triggers: every HOP-th accepted sample after that.
- On trigger, start address = wr_ptr_new - FRAME_LEN (mod depth), where wr_ptr_new is wr_ptr after the increment.

Reader FSM:
- IDLE: on a trigger, or with pending set, load rd_addr with the start address, clear pending, go to FETCH.
- FETCH: issue the synchronous RAM read, go to STREAM.
- STREAM: present samples in order. On each m_tvalid&&m_tready, advance; prefetch keeps the stream gap-free while m_tready stays high. After the FRAME_LEN-th transfer (m_tlast=1), increment m_frame_idx and go to IDLE.

Pending and overrun:
- A trigger while the FSM is busy stores its start address in a single pending slot.
- A trigger while pending is already set is dropped and sets overrun.
- If the writer passes the active frame start address before the frame completes, overrun is set. The frame still finishes and its data may be corrupt.

Simultaneous events:
- Write and read in the same cycle use independent RAM ports.
- Same-address read and write returns the old data. This cannot occur in a legal frame.
- A trigger in the same cycle as a frame's final transfer goes straight to FETCH, with no IDLE cycle.

Arithmetic:
- All samples are signed 24-bit.
- Pre-emphasis: y = x - ((x_prev * PRE_EMPH_COEF) >>> 15).
  - The product is 40-bit signed; the shift is arithmetic.
  - y is computed at 25 bits and saturated to [-2^23, 2^23-1].
- x_prev holds the last raw accepted sample; reset value is 0.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, m_frame_idx=0, overrun=0. All pointers, counters, pending and x_prev are 0; FSM is IDLE.
- Reset is asynchronous, so outputs clear immediately.
- Reset in mid-frame abandons the frame, and buffer contents are considered empty.
- Latency: the triggering input strobe in cycle N gives m_tvalid=1 in cycle N+3 (write, read issue, output register).
- While m_tready=1, there is one sample per cycle with no gaps.
- A frame therefore takes FRAME_LEN+2 cycles with no backpressure.
- While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_frame_idx hold stable.
- m_tvalid never drops before its transfer completes.
- m_frame_idx is stable for the whole frame.
- The input needs no backpressure: at 48 kHz into 100 MHz there are about 2083 cycles per sample.

## Configuration
- FRAMER_PREEMPH_EN defined: the pre-emphasis filter is in the input path, adding no extra latency (computed combinationally before the RAM write register).
- FRAMER_PREEMPH_EN undefined: raw samples are stored, the multiplier and x_prev are removed, and PRE_EMPH_COEF is ignored.

## Test plan
- Fill (macro off, FRAME_LEN=8, HOP=4, samples 1..8 on left strobes every 20 cycles, m_tready=1):
  - m_tvalid rises 3 cycles after the 8th strobe.
  - Data is 1..8 with m_tlast on 8; m_frame_idx=0.
- Overlap: continue with samples 9..12 -> frame 1 is 5..12, m_frame_idx=1.
- Channel select (CHOOSE_CHANNEL=0, right strobes interleaved with value 999) -> 999 never appears on m_tdata.
- Backpressure: m_tready toggles 1,0,0,1 during a frame -> data is held on stall cycles, there are no duplicates or skips, and exactly FRAME_LEN transfers occur.
- Overrun: m_tready=0 while 3 frame triggers arrive -> the second trigger goes pending, the third sets overrun=1. Asserting cmn_rst mid-frame clears m_tvalid and overrun asynchronously.
- Pre-emphasis (macro on, inputs 0x100000 then 0x100000):
  - outputs are 0x100000, then 0x100000-0x0F8520 = 0x007AE0;
  - inputs 0x7FFFFF then 0x800000 give the second output saturated to 0x800000.
